// File: rtl/strobed_debouncer.sv
// -----------------------------------------------------------------------------
// strobed_debouncer
//
// Debounces one raw mechanical push-button. The pin is synchronised every
// Clock, but the debounce state machine only advances on Strobe_i ticks from
// the upstream strobe generator. The debounce time is therefore
// STABLE_SAMPLES strobe periods, whatever the Clock frequency is.
//
// Parameters
//   STABLE_SAMPLES : consecutive identical samples needed to accept a change
//                    (1..255)
//   ACTIVE_LOW     : 1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed
//   REPEAT_DELAY   : strobes from the accepted press to the first Repeat_o
//   REPEAT_RATE    : strobes between later Repeat_o pulses
//
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Strobe_i   in   sample tick, one Clock wide (held high = one sample/cycle)
//   Button_i   in   raw asynchronous button pin
//   State_o    out  debounced level, 1 = pressed regardless of ACTIVE_LOW
//   Pressed_o  out  one-Clock pulse on an accepted press
//   Released_o out  one-Clock pulse on an accepted release
//   Repeat_o   out  one-Clock autorepeat pulse while the button is held
//
// Build option
//   DEBOUNCE_AUTOREPEAT_EN : when defined, builds the autorepeat counter that
//   drives Repeat_o. When undefined, Repeat_o is tied to 0.
// -----------------------------------------------------------------------------
module strobed_debouncer #(
  parameter int STABLE_SAMPLES = 4,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Strobe_i,
  input  logic Button_i,
  output logic State_o,
  output logic Pressed_o,
  output logic Released_o,
  output logic Repeat_o
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int                CNT_W     = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  // Pin level while the button is not pressed; the synchroniser resets to it
  // so that leaving reset never looks like a press.
  localparam logic              IDLE_LEVEL    = ACTIVE_LOW;
  localparam logic              SINGLE_SAMPLE = (STABLE_SAMPLES == 1);

  // Catch illegal configurations at elaboration rather than in silicon.
  if (STABLE_SAMPLES < 1 || STABLE_SAMPLES > 255 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("strobed_debouncer: parameter out of range");
  end

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, clocked every cycle independent of Strobe_i
  // ---------------------------------------------------------------------------
  logic sync_meta;
  logic sync_q;

  always_ff @(posedge Clock) begin
    // NOTE: sequential state always uses <=, so every flop samples the value
    // from before this edge; with = the second flop would see the new value of
    // the first and the two-stage chain would collapse into one stage.
    if (Reset) begin
      sync_meta <= IDLE_LEVEL;
      sync_q    <= IDLE_LEVEL;
    end else begin
      sync_meta <= Button_i;
      sync_q    <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample decode
  // ---------------------------------------------------------------------------
  logic sample;     // synchronised pin, 1 = pressed
  logic count_hit;  // this sample completes the required run
  logic strobe_ok;  // strobe that the FSM is allowed to act on

  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    sample    = sync_q ^ ACTIVE_LOW;
    count_hit = (cnt_q == CNT_LAST);
    strobe_ok = Strobe_i;
    // With a single required sample and Strobe_i held high, a press and a
    // release could complete on adjacent cycles. Holding off for the one
    // cycle an event pulse is high keeps the two pulses apart. With two or
    // more samples the count itself already guarantees the gap.
    if (SINGLE_SAMPLE && (Pressed_o || Released_o)) begin
      strobe_ok = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM with registered level and event outputs
  // ---------------------------------------------------------------------------
  // In the stable states the counter is 0, so count_hit there is true only
  // when a single sample is enough; that lets RELEASED/PRESS_PEND (and the
  // mirror pair) share one transition rule.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      State_o    <= 1'b0;
      Pressed_o  <= 1'b0;
      Released_o <= 1'b0;
    end else begin
      Pressed_o  <= 1'b0;
      Released_o <= 1'b0;
      if (strobe_ok) begin
        case (state_q)
          RELEASED, PRESS_PEND: begin
            if (sample) begin
              if (count_hit) begin
                state_q   <= PRESSED;
                cnt_q     <= '0;
                State_o   <= 1'b1;
                Pressed_o <= 1'b1;
              end else begin
                state_q <= PRESS_PEND;
                cnt_q   <= cnt_q + CNT_ONE;
              end
            end else begin
              // Bounce back: the run is broken and must start over.
              state_q <= RELEASED;
              cnt_q   <= '0;
            end
          end
          PRESSED, RELEASE_PEND: begin
            if (!sample) begin
              if (count_hit) begin
                state_q    <= RELEASED;
                cnt_q      <= '0;
                State_o    <= 1'b0;
                Released_o <= 1'b1;
              end else begin
                state_q <= RELEASE_PEND;
                cnt_q   <= cnt_q + CNT_ONE;
              end
            end else begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            State_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  // ---------------------------------------------------------------------------
  // Autorepeat: counts strobes while the debounced level is high. The first
  // period is REPEAT_DELAY strobes long, every later one REPEAT_RATE. A bounce
  // through RELEASE_PEND keeps counting; only a completed release clears it.
  // ---------------------------------------------------------------------------
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  logic [RPT_W-1:0] rpt_cnt_q;
  logic             rpt_in_rate_q;  // first repeat already issued
  logic [RPT_W-1:0] rpt_last;
  logic             release_done;   // FSM enters RELEASED on this edge

  always_comb begin
    rpt_last     = rpt_in_rate_q ? RATE_LAST : DELAY_LAST;
    release_done = strobe_ok && !sample && count_hit &&
                   (state_q == PRESSED || state_q == RELEASE_PEND);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rpt_cnt_q     <= '0;
      rpt_in_rate_q <= 1'b0;
      Repeat_o      <= 1'b0;
    end else begin
      Repeat_o <= 1'b0;
      if (release_done) begin
        // Clearing wins over a repeat that would fall on the same strobe,
        // so no repeat is ever issued together with the release event.
        rpt_cnt_q     <= '0;
        rpt_in_rate_q <= 1'b0;
      end else if (Strobe_i && State_o) begin
        if (rpt_cnt_q == rpt_last) begin
          rpt_cnt_q     <= '0;
          rpt_in_rate_q <= 1'b1;
          Repeat_o      <= 1'b1;
        end else begin
          rpt_cnt_q <= rpt_cnt_q + RPT_ONE;
        end
      end
    end
  end
`else
  assign Repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_strobed_debouncer.sv
// -----------------------------------------------------------------------------
// tb_strobed_debouncer
//
// Directed bench for strobed_debouncer: STABLE_SAMPLES = 4, ACTIVE_LOW = 1,
// REPEAT_DELAY = 8, REPEAT_RATE = 2, one strobe every 10 clocks. Strobe
// indices are counted per scenario; an event pulse is seen on the step that
// follows the edge at which the completing strobe was sampled.
// -----------------------------------------------------------------------------
module tb_strobed_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic strobe = 1'b0;
  logic button = 1'b1;
  logic state, pressed, released, rpt;

  strobed_debouncer #(
    .STABLE_SAMPLES (4),
    .ACTIVE_LOW     (1'b1),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (2)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Strobe_i   (strobe),
    .Button_i   (button),
    .State_o    (state),
    .Pressed_o  (pressed),
    .Released_o (released),
    .Repeat_o   (rpt)
  );

  always #50 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observation state, updated once per clock by step()
  int   cyc = 0;
  int   strobe_idx = 0;
  logic last_s = 1'b0;
  int   n_pressed, n_released, n_repeat, n_state_hi;
  int   press_at, release_at;
  logic press_on_strobe, state_before_press;
  logic prev_state = 1'b0;
  logic prev_evt = 1'b0;
  int   n_rep_off_strobe;
  int   tot_both = 0;
  int   tot_consec = 0;
  int   rep_q[$];

  task automatic step();
    logic s;
    s = strobe;
    @(posedge clk);
    #1;
    cyc++;
    last_s = s;
    if (s) strobe_idx++;
    if (pressed) begin
      n_pressed++;
      press_at = strobe_idx;
      press_on_strobe = s;
      state_before_press = prev_state;
    end
    if (released) begin
      n_released++;
      release_at = strobe_idx;
    end
    if (rpt) begin
      n_repeat++;
      rep_q.push_back(strobe_idx);
      if (!s) n_rep_off_strobe++;
    end
    if (pressed && released) tot_both++;
    if ((pressed || released) && prev_evt) tot_consec++;
    prev_evt = pressed || released;
    if (state) n_state_hi++;
    prev_state = state;
    strobe = ((cyc % 10) == 0);
  endtask

  task automatic clear_counts();
    strobe_idx = 0;
    n_pressed = 0; n_released = 0; n_repeat = 0; n_state_hi = 0;
    press_at = -1; release_at = -1;
    press_on_strobe = 1'b0; state_before_press = 1'bx;
    n_rep_off_strobe = 0;
    rep_q.delete();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until a strobe has just been sampled, so the next one is 10
  // edges away and a pin change made now reaches the FSM before it.
  task automatic align();
    int budget;
    budget = 25;
    step();
    while (!last_s && budget > 0) begin
      step();
      budget--;
    end
    if (!last_s) begin
      checks++; errors++;
      $display("FAIL align_timeout: got no strobe within %0d cycles expected one", 25);
    end
  endtask

  task automatic run_strobes(input int n);
    int target, budget;
    target = strobe_idx + n;
    budget = n * 10 + 20;
    while (strobe_idx < target && budget > 0) begin
      step();
      budget--;
    end
    if (strobe_idx < target) begin
      checks++; errors++;
      $display("FAIL strobe_wait: got %0d strobes expected %0d", strobe_idx, target);
    end
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    steps(n);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    button = 1'b1;
    pulse_reset(3);
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", state); end
    checks++;
    if ({pressed, released, rpt} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {pressed, released, rpt});
    end
    clear_counts();
    steps(100);
    checks++;
    if (n_state_hi !== 0) begin errors++; $display("FAIL reset_idle_state: got %0d high cycles expected 0", n_state_hi); end
    checks++;
    if (n_pressed + n_released + n_repeat !== 0) begin
      errors++; $display("FAIL reset_idle_pulses: got %0d pulses expected 0", n_pressed + n_released + n_repeat);
    end
  endtask

  task automatic test_clean_press();
    align();
    clear_counts();
    button = 1'b0;
    run_strobes(4);
    steps(5);
    checks++;
    if (n_pressed !== 1) begin errors++; $display("FAIL press_count: got %0d expected 1", n_pressed); end
    checks++;
    if (press_at !== 4) begin errors++; $display("FAIL press_strobe: got %0d expected 4", press_at); end
    checks++;
    if (press_on_strobe !== 1'b1) begin errors++; $display("FAIL press_latency: got %b expected 1", press_on_strobe); end
    checks++;
    if (state_before_press !== 1'b0) begin errors++; $display("FAIL press_state_before: got %b expected 0", state_before_press); end
    checks++;
    if (state !== 1'b1) begin errors++; $display("FAIL press_state_after: got %b expected 1", state); end
  endtask

  task automatic test_release();
    // Two-clock glitch between strobes is never sampled.
    align();
    clear_counts();
    steps(3);
    button = 1'b1;
    steps(2);
    button = 1'b0;
    run_strobes(2);
    checks++;
    if (n_released !== 0) begin errors++; $display("FAIL glitch_release: got %0d expected 0", n_released); end
    checks++;
    if (state !== 1'b1) begin errors++; $display("FAIL glitch_state: got %b expected 1", state); end
    // Held release.
    clear_counts();
    button = 1'b1;
    run_strobes(4);
    steps(3);
    checks++;
    if (n_released !== 1) begin errors++; $display("FAIL release_count: got %0d expected 1", n_released); end
    checks++;
    if (release_at !== 4) begin errors++; $display("FAIL release_strobe: got %0d expected 4", release_at); end
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL release_state: got %b expected 0", state); end
    checks++;
    if (n_pressed !== 0) begin errors++; $display("FAIL release_no_press: got %0d expected 0", n_pressed); end
  endtask

  task automatic test_bounce();
    align();
    clear_counts();
    button = 1'b0;
    run_strobes(3);
    button = 1'b1;
    run_strobes(1);
    button = 1'b0;
    run_strobes(4);
    steps(3);
    checks++;
    if (n_pressed !== 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", n_pressed); end
    checks++;
    if (press_at !== 8) begin errors++; $display("FAIL bounce_strobe: got %0d expected 8", press_at); end
  endtask

  task automatic test_reset_release_pend();
    align();
    clear_counts();
    button = 1'b1;
    run_strobes(2);
    checks++;
    if (state !== 1'b1) begin errors++; $display("FAIL rpend_state_hold: got %b expected 1", state); end
    steps(3);
    pulse_reset(3);
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL rpend_reset_state: got %b expected 0", state); end
    steps(30);
    checks++;
    if (n_released + n_pressed !== 0) begin
      errors++; $display("FAIL rpend_reset_pulses: got %0d expected 0", n_released + n_pressed);
    end
  endtask

  task automatic test_reset_mid_press();
    align();
    clear_counts();
    button = 1'b0;
    run_strobes(2);
    steps(3);
    pulse_reset(3);
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL midpress_state: got %b expected 0", state); end
    checks++;
    if (n_pressed !== 0) begin errors++; $display("FAIL midpress_pulse: got %0d expected 0", n_pressed); end
    clear_counts();
    run_strobes(3);
    checks++;
    if (n_pressed !== 0) begin errors++; $display("FAIL midpress_early: got %0d expected 0", n_pressed); end
    run_strobes(1);
    steps(2);
    checks++;
    if (n_pressed !== 1 || press_at !== 4) begin
      errors++; $display("FAIL midpress_full: got %0d at strobe %0d expected 1 at strobe 4", n_pressed, press_at);
    end
    button = 1'b1;
    run_strobes(4);
    steps(3);
  endtask

`ifdef DEBOUNCE_AUTOREPEAT_EN
  task automatic test_autorepeat();
    align();
    clear_counts();
    button = 1'b0;
    run_strobes(4);
    run_strobes(20);
    steps(2);
    checks++;
    if (n_repeat !== 7) begin errors++; $display("FAIL repeat_count: got %0d expected 7", n_repeat); end
    for (int k = 0; k < rep_q.size() && k < 7; k++) begin
      checks++;
      if (rep_q[k] !== 12 + 2 * k) begin
        errors++; $display("FAIL repeat_strobe_%0d: got %0d expected %0d", k, rep_q[k], 12 + 2 * k);
      end
    end
    checks++;
    if (n_rep_off_strobe !== 0) begin errors++; $display("FAIL repeat_latency: got %0d late pulses expected 0", n_rep_off_strobe); end
    button = 1'b1;
    run_strobes(4);
    steps(2);
    checks++;
    if (n_released !== 1) begin errors++; $display("FAIL repeat_release: got %0d expected 1", n_released); end
    clear_counts();
    run_strobes(5);
    checks++;
    if (n_repeat !== 0) begin errors++; $display("FAIL repeat_after_release: got %0d expected 0", n_repeat); end
    // A new press restarts the full delay.
    clear_counts();
    button = 1'b0;
    run_strobes(12);
    steps(2);
    checks++;
    if (n_repeat !== 1 || (rep_q.size() > 0 && rep_q[0] !== 12)) begin
      errors++; $display("FAIL repeat_restart: got %0d pulses expected 1 at strobe 12", n_repeat);
    end
    button = 1'b1;
    run_strobes(4);
    steps(3);
  endtask
`else
  task automatic test_autorepeat();
    align();
    clear_counts();
    button = 1'b0;
    run_strobes(24);
    steps(2);
    checks++;
    if (n_pressed !== 1) begin errors++; $display("FAIL norepeat_press: got %0d expected 1", n_pressed); end
    checks++;
    if (n_repeat !== 0) begin errors++; $display("FAIL norepeat_pulses: got %0d expected 0", n_repeat); end
    button = 1'b1;
    run_strobes(4);
    steps(3);
  endtask
`endif

  task automatic test_event_rules();
    checks++;
    if (tot_both !== 0) begin errors++; $display("FAIL events_together: got %0d expected 0", tot_both); end
    checks++;
    if (tot_consec !== 0) begin errors++; $display("FAIL events_consecutive: got %0d expected 0", tot_consec); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_release_pend();
    test_reset_mid_press();
    test_autorepeat();
    test_event_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
